// File: rtl/uart_echo_responder.sv
// 8N1 UART receiver feeding a circular echo FIFO that drains into an 8N1 transmitter.
// rx_valid to tx start edge is 2 clk; echo_en gates only new frames, and full FIFO drops and flags overflow.
module uart_echo_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_serial,
  input  logic                          echo_en,
  output logic                          tx_serial,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t       rx_state, rx_state_nxt;
  tx_state_t       tx_state, tx_state_nxt;
  logic            rx_meta, rx_sync, rx_prev;
  logic [1:0]      sync_vld;
  logic [CW-1:0]   rx_cnt, tx_cnt;
  logic [2:0]      rx_bit, tx_bit;
  logic [7:0]      rx_shift, tx_shift;
  logic            rx_tick, rx_good, rx_bad, rx_fall;
  logic            tx_last, tx_pop, can_pop;
  logic            fifo_full, push_ok;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];

  // rx_prev only goes high once a real (post-reset) high has crossed the synchronizer,
  // so a line held low through reset can never look like a start bit.
  assign rx_fall = rx_prev & ~rx_sync;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tick      = 1'b0;
    rx_good      = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state)
      RX_IDLE:    if (rx_fall) rx_state_nxt = RX_START;
      RX_START:   if (rx_cnt == HALF) begin
                    rx_tick      = 1'b1;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                  end
      RX_DATA:    if (rx_cnt == LAST) begin
                    rx_tick = 1'b1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                  end
      RX_STOP:    if (rx_cnt == LAST) begin
                    rx_tick      = 1'b1;
                    rx_good      = rx_sync;
                    rx_bad       = ~rx_sync;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_RECOVER;
                  end
      RX_RECOVER: if (rx_sync) rx_state_nxt = RX_IDLE;
      default:    rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_vld  <= 2'b00;
      rx_prev   <= 1'b0;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx_serial;
      rx_sync   <= rx_meta;
      sync_vld  <= {sync_vld[0], 1'b1};
      rx_prev   <= rx_sync & sync_vld[1];
      rx_state  <= rx_state_nxt;
      rx_cnt    <= (rx_tick || rx_state == RX_IDLE || rx_state == RX_RECOVER) ? '0 : rx_cnt + CW'(1);
      if (rx_state == RX_IDLE) rx_bit <= 3'd0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      rx_valid  <= rx_good;
      frame_err <= rx_bad;
      if (rx_good) rx_data <= rx_shift;
    end
  end

  // A push into a full FIFO still lands when TX pops the head in the same cycle.
  assign fifo_full = (fifo_count == FULL);
  assign push_ok   = rx_valid & (~fifo_full | tx_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, tx_pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      overflow <= overflow | (rx_valid & fifo_full & ~tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  assign tx_last = (tx_cnt == LAST);
  assign can_pop = echo_en && (fifo_count != '0);

  // Popping in the last stop cycle lets back-to-back frames run with no idle gap.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE:  if (can_pop) begin
                  tx_pop       = 1'b1;
                  tx_state_nxt = TX_START;
                end
      TX_START: if (tx_last) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_last && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_last) begin
                  tx_pop       = can_pop;
                  tx_state_nxt = can_pop ? TX_START : TX_IDLE;
                end
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= (tx_last || tx_state == TX_IDLE) ? '0 : tx_cnt + CW'(1);
      if (tx_pop) begin
        tx_serial <= 1'b0;
        tx_busy   <= 1'b1;
        tx_shift  <= mem[rd_ptr];
      end else begin
        case (tx_state)
          TX_START: if (tx_last) begin
                      tx_serial <= tx_shift[0];
                      tx_bit    <= 3'd0;
                    end
          TX_DATA:  if (tx_last) begin
                      if (tx_bit == 3'd7) begin
                        tx_serial <= 1'b1;
                      end else begin
                        tx_serial <= tx_shift[1];
                        tx_shift  <= {1'b0, tx_shift[7:1]};
                      end
                      tx_bit <= tx_bit + 3'd1;
                    end
          TX_STOP:  if (tx_last) tx_busy <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: drives serial frames, decodes tx_serial, and scores
// against a queue-based model of the echo buffer.
module tb_uart_echo_responder;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_serial = 1'b0;
  logic       echo_en = 1'b0;
  logic       tx_serial, rx_valid, frame_err, overflow, tx_busy;
  logic [7:0] rx_data;
  logic [3:0] fifo_count;

  uart_echo_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .echo_en(echo_en),
    .tx_serial(tx_serial), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_rx[$];
  logic [7:0] mdl_q[$];
  bit         mdl_ovf = 1'b0;
  int         n_rxv = 0, n_ferr = 0, exp_ferr = 0, n_tx = 0;
  int         rxv_cyc = 0, fall_cyc = 0;
  int         fall_q[$];
  logic [7:0] rb;

  bit         dec_active = 1'b0;
  int         dec_k = 0, dec_bad = 0;
  logic [7:0] dec_b, dec_exp;
  logic [9:0] dec_frame;
  logic       tx_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) exp_rx.push_back(b);
    else exp_ferr++;
    for (int i = 0; i < 10; i++) begin
      rx_serial = f[i];
      cycles(CPB);
    end
    rx_serial = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx_serial = 1'b0;
    cycles(len);
    rx_serial = 1'b1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((mdl_q.size() != 0 || dec_active || tx_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", (t < 5000), 1);
  endtask

  // Monitor: scores received bytes, keeps the echo-buffer model, and decodes TX frames.
  always @(negedge clk) begin
    if (!reset) begin
      dec_active = 1'b0;
      mdl_q.delete();
      mdl_ovf = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (rx_valid) begin
        n_rxv++;
        rxv_cyc = cyc;
        if (exp_rx.size() == 0) begin
          check("rx_unexpected_pulse", rx_valid, 0);
          rb = rx_data;
        end else begin
          rb = exp_rx.pop_front();
          check("rx_data", rx_data, rb);
        end
        if (mdl_q.size() < DEPTH || (echo_en && !tx_busy)) mdl_q.push_back(rb);
        else mdl_ovf = 1'b1;
      end
      if (frame_err) n_ferr++;
      if (!dec_active && tx_prev && !tx_serial) begin
        dec_active = 1'b1;
        dec_k = 0;
        dec_bad = 0;
        fall_cyc = cyc;
        fall_q.push_back(cyc);
        n_tx++;
        if (mdl_q.size() == 0) begin
          check("tx_unexpected_start", tx_serial, 1);
          dec_exp = 8'h00;
        end else begin
          dec_exp = mdl_q.pop_front();
        end
        dec_frame = {1'b1, dec_exp, 1'b0};
      end
      if (dec_active) begin
        if (tx_serial !== dec_frame[dec_k / CPB] || tx_busy !== 1'b1) dec_bad++;
        if (dec_k % CPB == CPB / 2 && dec_k >= CPB + CPB / 2 && dec_k <= 8 * CPB + CPB / 2)
          dec_b[dec_k / CPB - 1] = tx_serial;
        if (dec_k == FRAME - 1) begin
          dec_active = 1'b0;
          check("tx_byte", dec_b, dec_exp);
          check("tx_frame_shape_errs", dec_bad, 0);
        end else begin
          dec_k++;
        end
      end
      tx_prev = tx_serial;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, rxv0, ferr0, kind, t;
    bit seen;
    logic [7:0] b;

    // Reset state, with the line held low through and after reset.
    cycles(4);
    @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    cycles(1);
    reset = 1'b1;
    cycles(200);
    rx_serial = 1'b1;
    cycles(30);
    check("low_after_reset_ferr", n_ferr, 0);
    check("low_after_reset_rxv", n_rxv, 0);

    // Single echo of A5 and its start-edge latency.
    echo_en = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_drain();
    check("echo_latency", fall_cyc - rxv_cyc, 2);
    check("echo_tx_count", n_tx, 1);
    cycles(2);

    // Framing error followed by a good byte.
    tx0 = n_tx; rxv0 = n_rxv;
    send_frame(8'h3C, 1'b0);
    cycles(20);
    check("ferr_pulses", n_ferr, exp_ferr);
    check("ferr_no_rxv", n_rxv, rxv0);
    check("ferr_no_tx", n_tx, tx0);
    check("ferr_fifo_count", fifo_count, 0);
    send_frame(8'h11, 1'b1);
    wait_drain();
    cycles(2);

    // Short glitch must be rejected silently.
    rxv0 = n_rxv; ferr0 = n_ferr;
    glitch(5);
    cycles(40);
    check("glitch_no_rxv", n_rxv, rxv0);
    check("glitch_no_ferr", n_ferr, ferr0);

    // Randomized mix of good bytes, bad stop bits and glitches.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 5);
      b = 8'($urandom);
      if (kind <= 3) begin
        send_frame(b, 1'b1);
        cycles($urandom_range(3, 12));
      end else if (kind == 4) begin
        send_frame(b, 1'b0);
        cycles($urandom_range(3, 12));
      end else begin
        glitch($urandom_range(1, 7));
        cycles($urandom_range(20, 40));
      end
    end
    wait_drain();
    check("rand_ferr", n_ferr, exp_ferr);
    check("rand_rx_pending", exp_rx.size(), 0);
    cycles(2);

    // Overflow: nine bytes into an eight-entry buffer with echo disabled.
    echo_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
      cycles(3);
    end
    cycles(10);
    check("ovf_fifo_count", fifo_count, mdl_q.size());
    check("ovf_flag", overflow, mdl_ovf);
    fall_q.delete();
    echo_en = 1'b1;
    wait_drain();
    check("ovf_frames", fall_q.size(), DEPTH);
    check("ovf_back_to_back_span", fall_q[fall_q.size() - 1] - fall_q[0], (DEPTH - 1) * FRAME);
    check("ovf_drained", fifo_count, 0);
    cycles(2);

    // Reset during data bit 4 of an FF frame with three bytes still queued.
    echo_en = 1'b0;
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send_frame(8'($urandom), 1'b1);
      cycles(3);
    end
    cycles(5);
    echo_en = 1'b1;
    t = 0;
    while (!(dec_active && dec_k >= 5 * CPB + CPB / 2) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("mid_tx_reached", (t < 600), 1);
    check("mid_tx_queued", fifo_count, 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_tx_serial", tx_serial, 1);
    check("rst_mid_tx_busy", tx_busy, 0);
    check("rst_mid_fifo_count", fifo_count, 0);
    check("rst_mid_overflow", overflow, 0);
    cycles(1);
    reset = 1'b1;
    cycles(10);

    // Full buffer: TX pops in the very cycle a new byte is pushed.
    echo_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'($urandom), 1'b1);
      cycles(3);
    end
    cycles(10);
    check("full_fifo_count", fifo_count, DEPTH);
    fork
      send_frame(8'($urandom), 1'b1);
      begin
        t = 0;
        seen = 1'b0;
        while (!seen && t < 400) begin
          @(posedge clk);
          #1;
          t++;
          if (rx_valid) seen = 1'b1;
        end
        check("pp_rx_valid_seen", seen, 1);
        echo_en = 1'b1;
        repeat (3) @(negedge clk);
        check("pp_fifo_count", fifo_count, DEPTH);
        check("pp_overflow", overflow, 0);
      end
    join
    wait_drain();
    check("pp_overflow_end", overflow, 0);
    check("pp_fifo_drained", fifo_count, 0);

    check("end_rx_pending", exp_rx.size(), 0);
    check("end_ferr", n_ferr, exp_ferr);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
